// File: rtl/raster_scan_if.sv
// Pixel interface between the raster generator (master) and the renderers/display side (slave).
interface raster_scan_if;
  logic        ce_i;
  logic        pixel_i;
  logic [9:0]  pixel_x_o;
  logic [9:0]  pixel_y_o;
  logic [11:0] rgb_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        de_o;
  logic        frame_o;

  modport master (
    input  ce_i, pixel_i,
    output pixel_x_o, pixel_y_o, rgb_o, hsync_o, vsync_o, de_o, frame_o
  );

  modport slave (
    output ce_i, pixel_i,
    input  pixel_x_o, pixel_y_o, rgb_o, hsync_o, vsync_o, de_o, frame_o
  );
endinterface

// File: rtl/raster_scan.sv
// Raster timing generator: sweeps x/y, delays timing flags to match renderer latency,
// and registers the colour/sync/de stream plus a per-frame tick.
module raster_scan #(
  parameter int          H_ACTIVE      = 640,
  parameter int          H_FP          = 16,
  parameter int          H_SYNC        = 96,
  parameter int          H_BP          = 48,
  parameter int          V_ACTIVE      = 240,
  parameter int          V_FP          = 4,
  parameter int          V_SYNC        = 3,
  parameter int          V_BP          = 15,
  parameter int          PIXEL_LATENCY = 0,
  parameter bit          SYNC_ACT_LOW  = 1'b1,
  parameter logic [11:0] FG_RGB        = 12'hFFF,
  parameter logic [11:0] BG_RGB        = 12'h000
) (
  input  logic          clk_i,
  input  logic          rst_i,
  raster_scan_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // 11-bit bounds so a sync window ending exactly at 1024 cannot wrap
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0]  X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);

  logic [9:0] x, y;
  logic       x_last, y_last;
  logic       active, hs, vs;
  logic [2:0] flags_now, flags_d;

  assign x_last = (x == X_LAST);
  assign y_last = (y == Y_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x <= '0;
      y <= '0;
    end else if (bus.ce_i) begin
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + 10'd1;
      end else begin
        x <= x + 10'd1;
      end
    end
  end

  assign bus.pixel_x_o = x;
  assign bus.pixel_y_o = y;

  assign active = ({1'b0, x} < H_ACT) && ({1'b0, y} < V_ACT);
  assign hs     = ({1'b0, x} >= HS_START) && ({1'b0, x} < HS_END);
  assign vs     = ({1'b0, y} >= VS_START) && ({1'b0, y} < VS_END);
  assign flags_now = {active, hs, vs};

  // Flags are held active-high internally; polarity is applied only at the pins
  generate
    if (PIXEL_LATENCY == 0) begin : g_no_delay
      assign flags_d = flags_now;
    end else begin : g_delay
      logic [3*PIXEL_LATENCY-1:0] sr;
      logic [3*PIXEL_LATENCY+2:0] sr_ext;

      assign sr_ext = {sr, flags_now};

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
          sr <= '0;
        else if (bus.ce_i)
          sr <= sr_ext[3*PIXEL_LATENCY-1:0];
      end

      assign flags_d = sr[3*PIXEL_LATENCY-1 -: 3];
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.rgb_o   <= '0;
      bus.de_o    <= 1'b0;
      bus.hsync_o <= SYNC_ACT_LOW;
      bus.vsync_o <= SYNC_ACT_LOW;
      bus.frame_o <= 1'b0;
    end else begin
      bus.frame_o <= bus.ce_i && x_last && y_last;
      if (bus.ce_i) begin
        bus.de_o    <= flags_d[2];
        bus.rgb_o   <= flags_d[2] ? (bus.pixel_i ? FG_RGB : BG_RGB) : 12'h000;
        bus.hsync_o <= flags_d[1] ^ SYNC_ACT_LOW;
        bus.vsync_o <= flags_d[0] ^ SYNC_ACT_LOW;
      end
    end
  end
endmodule

// File: tb/tb_raster_scan.sv
// Scoreboard bench: two raster_scan instances (latency 0 active-low sync, latency 2 active-high)
// on a shrunken screen, checked strobe by strobe against a coordinate model.
module tb_raster_scan;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, HT = HA + HF + HS + HB;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int LAT1 = 2;

  typedef struct {
    int x;
    int y;
    bit valid;
  } ent_t;

  typedef struct {
    logic [11:0] rgb;
    logic        de;
    logic        hs;
    logic        vs;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b0;
  logic p0 = 1'b0, p1 = 1'b0;

  raster_scan_if if0 ();
  raster_scan_if if1 ();

  assign if0.ce_i    = ce;
  assign if1.ce_i    = ce;
  assign if0.pixel_i = p0;
  assign if1.pixel_i = p1;

  raster_scan #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIXEL_LATENCY(0), .SYNC_ACT_LOW(1'b1)
  ) u0 (.clk_i(clk), .rst_i(rst), .bus(if0));

  raster_scan #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIXEL_LATENCY(LAT1), .SYNC_ACT_LOW(1'b0)
  ) u1 (.clk_i(clk), .rst_i(rst), .bus(if1));

  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0;
  int   mx = 0, my = 0;
  int   mode = 2;
  ent_t q[$];
  out_t exp0, exp1;
  bit   exp_fr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (x=%0d y=%0d t=%0t)", tag, got, want, mx, my, $time);
  endtask

  function automatic bit pix(input ent_t e);
    case (mode)
      0:       return ((e.x * 3 + e.y) % 5 == 0) || (e.x % 4 == 1);
      1:       return (e.x == 5) && (e.y == 3);
      default: return 1'b1;
    endcase
  endfunction

  function automatic out_t calc(input ent_t e, input bit p, input bit act_low);
    out_t o;
    bit a, h, v;
    a = e.valid && e.x < HA && e.y < VA;
    h = e.valid && e.x >= HA + HF && e.x < HA + HF + HS;
    v = e.valid && e.y >= VA + VF && e.y < VA + VF + VS;
    o.rgb = a ? (p ? 12'hFFF : 12'h000) : 12'h000;
    o.de  = a;
    o.hs  = h ^ act_low;
    o.vs  = v ^ act_low;
    return o;
  endfunction

  task automatic model_reset();
    ent_t idle;
    idle = '{x: 0, y: 0, valid: 1'b0};
    mx = 0;
    my = 0;
    q.delete();
    for (int i = 0; i < LAT1; i++) q.push_back(idle);
    exp0 = calc(idle, 1'b0, 1'b1);
    exp1 = calc(idle, 1'b0, 1'b0);
    exp_fr = 1'b0;
  endtask

  task automatic compare_all();
    check("x0", 32'(if0.pixel_x_o), 32'(mx));
    check("y0", 32'(if0.pixel_y_o), 32'(my));
    check("x1", 32'(if1.pixel_x_o), 32'(mx));
    check("y1", 32'(if1.pixel_y_o), 32'(my));
    check("rgb0", 32'(if0.rgb_o), 32'(exp0.rgb));
    check("de0", 32'(if0.de_o), 32'(exp0.de));
    check("hs0", 32'(if0.hsync_o), 32'(exp0.hs));
    check("vs0", 32'(if0.vsync_o), 32'(exp0.vs));
    check("rgb1", 32'(if1.rgb_o), 32'(exp1.rgb));
    check("de1", 32'(if1.de_o), 32'(exp1.de));
    check("hs1", 32'(if1.hsync_o), 32'(exp1.hs));
    check("vs1", 32'(if1.vsync_o), 32'(exp1.vs));
    check("frame0", 32'(if0.frame_o), 32'(exp_fr));
    check("frame1", 32'(if1.frame_o), 32'(exp_fr));
  endtask

  // One clock: ce_v=1 issues the current model coordinate and retires the oldest queued one
  task automatic step(input bit ce_v);
    ent_t cur, front;
    cur = '{x: mx, y: my, valid: 1'b1};
    if (ce_v) begin
      q.push_back(cur);
      front = q[0];
      p0 = pix(cur);
      p1 = front.valid ? pix(front) : 1'b1;
    end else begin
      p0 = 1'($urandom);
      p1 = 1'($urandom);
    end
    ce = ce_v;
    @(posedge clk);
    #1;
    exp_fr = 1'b0;
    if (ce_v) begin
      front = q.pop_front();
      exp0 = calc(cur, p0, 1'b1);
      exp1 = calc(front, p1, 1'b0);
      exp_fr = (mx == HT - 1) && (my == VT - 1);
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx++;
      end
    end
    compare_all();
  endtask

  initial begin
    bit hit;
    int pulses;

    // Reset held with ce=1, pixel=1
    ce = 1'b1;
    p0 = 1'b1;
    p1 = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("rst_hs0_inactive", 32'(if0.hsync_o), 32'd1);
    check("rst_vs1_inactive", 32'(if1.vsync_o), 32'd0);
    #2 rst = 1'b0;

    mode = 2;
    step(1'b1);
    check("first_rgb", 32'(if0.rgb_o), 32'hFFF);
    check("first_de", 32'(if0.de_o), 32'd1);
    repeat (10) step(1'b1);

    mode = 0;
    pulses = 0;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      step(1'b1);
      if (if0.frame_o) pulses++;
    end
    check("frame_count", 32'(pulses), 32'd2);

    // Single lit coordinate through the latency-2 path
    mode = 1;
    for (int i = 0; i < HT * VT; i++) step(1'b1);

    // Half-rate strobe
    mode = 0;
    for (int i = 0; i < 2 * HT * VT + 7; i++) step(i % 2 == 0);

    // Run to a point inside both sync windows, then reset asynchronously
    hit = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !hit; i++) begin
      if (mx == HA + HF + 2 && my == VA + VF + 1) hit = 1'b1;
      else step(1'b1);
    end
    check("reach_sync", 32'(hit), 32'd1);
    step(1'b1);
    check("pre_rst_hs0", 32'(if0.hsync_o), 32'd0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    check("rst_hs0_inactive2", 32'(if0.hsync_o), 32'd1);
    check("rst_hs1_inactive2", 32'(if1.hsync_o), 32'd0);
    @(posedge clk);
    #3 rst = 1'b0;

    mode = 2;
    pulses = 0;
    for (int i = 0; i < HT * VT - 1; i++) begin
      step(1'b1);
      if (if0.frame_o || if1.frame_o) pulses++;
    end
    check("no_early_frame", 32'(pulses), 32'd0);
    step(1'b1);
    check("frame_after_full", 32'(if0.frame_o), 32'd1);
    repeat (20) step(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
